// File: rtl/psum_drain_requant_if.sv
// ---------------------------------------------------------------------------
// psum_drain_requant_if
// Output stream of the column drain stage: requantized activations on a
// valid/ready handshake, with an end-of-column marker.
//
//   out_valid  producer -> consumer  head entry is valid
//   out_ready  consumer -> producer  consumer accepts the head entry
//   out_data   producer -> consumer  requantized activation (DATA_WIDTH)
//   out_last   producer -> consumer  head entry is the last word of a drain
//
// master: the drain stage (drives valid/data/last)
// slave : the write-back path (drives ready)
// ---------------------------------------------------------------------------
interface psum_drain_requant_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_drain_requant.sv
// ---------------------------------------------------------------------------
// psum_drain_requant
// Drain stage for one PE column. On start it shifts NUM_PE partial sums out
// of the PE chain (pe_shift), requantizes each captured word (arithmetic
// right shift, optional rounding, saturation to signed or unsigned range),
// buffers it in a small FIFO and presents it on a valid/ready stream.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        one-cycle pulse, begins a drain when idle (ignored if busy)
//   rshift       requant right-shift amount, sampled on accepted start
//   out_signed   1: signed saturation, 0: unsigned, sampled on accepted start
//   psum_in      psum_out of the last PE in the column (signed)
//   pe_shift     shift / write enable for every PE in the column
//   busy         high from accepted start until the last word is popped
//   done         one-cycle pulse after the last word has been popped
//   stream       output stream (out_valid/out_ready/out_data/out_last)
//
// Build option:
//   DRAIN_ROUND_EN  defined: round-half-up before the shift
//                   undefined: plain truncation (no adder in the path)
// ---------------------------------------------------------------------------
module psum_drain_requant #(
    parameter int NUM_PE      = 8,
    parameter int PSUM_WIDTH  = 32,
    parameter int DATA_WIDTH  = 8,
    parameter int SHIFT_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [SHIFT_WIDTH-1:0]       rshift,
    input  logic                         out_signed,
    input  logic signed [PSUM_WIDTH-1:0] psum_in,
    output logic                         pe_shift,
    output logic                         busy,
    output logic                         done,
    psum_drain_requant_if.master         stream
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int EXT_W = PSUM_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] SMAX = EXT_W'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [EXT_W-1:0] SMIN = EXT_W'(-(2 ** (DATA_WIDTH - 1)));
    localparam logic signed [EXT_W-1:0] UMAX = EXT_W'((2 ** DATA_WIDTH) - 1);

    logic [1:0]             state_reg;
    logic [CNT_W-1:0]       word_cnt_reg;
    logic [SHIFT_WIDTH-1:0] rshift_reg;
    logic                   signed_reg;
    logic                   done_reg;
    logic [PTR_W-1:0]       wr_ptr_reg;
    logic [PTR_W-1:0]       rd_ptr_reg;
    logic [PTR_W:0]         fill_reg;
    logic [DATA_WIDTH:0]    fifo_mem [FIFO_DEPTH];

    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   push;
    logic                   last_word;
    logic [DATA_WIDTH:0]    head;

    logic signed [EXT_W-1:0]  ext;
    logic signed [EXT_W-1:0]  biased;
    logic signed [EXT_W-1:0]  shifted;
    logic [DATA_WIDTH-1:0]    sat;

    // ---------------- FIFO status / handshake ----------------
    assign fifo_empty = (fill_reg == '0);
    assign fifo_full  = (fill_reg == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop        = !fifo_empty && stream.out_ready;
    // A full FIFO can still accept a word when the head leaves this cycle.
    assign push       = (state_reg == ST_DRAIN) && (!fifo_full || pop);
    assign last_word  = (word_cnt_reg == CNT_W'(NUM_PE - 1));
    assign head       = fifo_mem[rd_ptr_reg];

    assign pe_shift        = push;
    assign busy            = (state_reg != ST_IDLE);
    assign done            = done_reg;
    assign stream.out_valid = !fifo_empty;
    // Storage is not reset; gate the head so outputs read zero when empty.
    assign stream.out_data  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
    assign stream.out_last  = !fifo_empty && head[DATA_WIDTH];

    // ---------------- Requantization ----------------
    always_comb begin
        ext = {psum_in[PSUM_WIDTH-1], psum_in};
`ifdef DRAIN_ROUND_EN
        // One extra bit of headroom keeps the half-LSB bias from overflowing.
        biased = ext + ((rshift_reg != '0)
                        ? (EXT_W'(1) << (rshift_reg - SHIFT_WIDTH'(1)))
                        : EXT_W'(0));
`else
        biased = ext;
`endif
        if (int'(rshift_reg) >= PSUM_WIDTH) begin
            shifted = {EXT_W{ext[EXT_W-1]}};
        end else begin
            shifted = biased >>> rshift_reg;
        end

        sat = shifted[DATA_WIDTH-1:0];
        if (signed_reg) begin
            if (shifted > SMAX) begin
                sat = SMAX[DATA_WIDTH-1:0];
            end else if (shifted < SMIN) begin
                sat = SMIN[DATA_WIDTH-1:0];
            end
        end else begin
            if (shifted[EXT_W-1]) begin
                sat = '0;
            end else if (shifted > UMAX) begin
                sat = UMAX[DATA_WIDTH-1:0];
            end
        end
    end

    // ---------------- FIFO storage ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {last_word, sat};
        end
    end

    // ---------------- Control ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            word_cnt_reg <= '0;
            rshift_reg   <= '0;
            signed_reg   <= 1'b0;
            done_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
        end else begin
            done_reg <= 1'b0;

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                fill_reg <= fill_reg + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                fill_reg <= fill_reg - (PTR_W + 1)'(1);
            end

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        rshift_reg   <= rshift;
                        signed_reg   <= out_signed;
                        word_cnt_reg <= '0;
                        state_reg    <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (push) begin
                        if (last_word) begin
                            word_cnt_reg <= '0;
                            state_reg    <= ST_WAIT;
                        end else begin
                            word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // The flagged entry is the final one, so its pop empties the FIFO.
                    if (pop && head[DATA_WIDTH]) begin
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_drain_requant.sv
// ---------------------------------------------------------------------------
// tb_psum_drain_requant
// Self-checking bench for psum_drain_requant. A behavioural PE column feeds
// psum_in and advances on pe_shift. Expected {last, data} words are queued
// when a drain is issued; a monitor process pops and compares each word the
// DUT hands over. Directed checks cover reset, backpressure, start-while-busy,
// reset mid-drain and back-to-back drains.
// ---------------------------------------------------------------------------
module tb_psum_drain_requant;

    localparam int NUM_PE      = 8;
    localparam int PSUM_WIDTH  = 32;
    localparam int DATA_WIDTH  = 8;
    localparam int SHIFT_WIDTH = 5;
    localparam int FIFO_DEPTH  = 4;

    logic                         clk = 1'b0;
    logic                         reset = 1'b1;
    logic                         start = 1'b0;
    logic [SHIFT_WIDTH-1:0]       rshift = '0;
    logic                         out_signed = 1'b1;
    logic signed [PSUM_WIDTH-1:0] psum_in;
    logic                         pe_shift;
    logic                         busy;
    logic                         done;

    psum_drain_requant_if #(.DATA_WIDTH(DATA_WIDTH)) stream_if ();

    always #5 clk = ~clk;

    psum_drain_requant #(
        .NUM_PE     (NUM_PE),
        .PSUM_WIDTH (PSUM_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rshift    (rshift),
        .out_signed(out_signed),
        .psum_in   (psum_in),
        .pe_shift  (pe_shift),
        .busy      (busy),
        .done      (done),
        .stream    (stream_if.master)
    );

    // Behavioural PE column: holds while pe_shift=0, advances one word per shift.
    logic signed [PSUM_WIDTH-1:0] chain_mem [NUM_PE];
    int                           chain_idx = 0;
    logic                         chain_load = 1'b0;

    always @(posedge clk) begin
        if (chain_load) chain_idx <= 0;
        else if (pe_shift && chain_idx < NUM_PE) chain_idx <= chain_idx + 1;
    end
    assign psum_in = (chain_idx < NUM_PE) ? chain_mem[chain_idx] : 32'sd0;

    // Scoreboard and counters
    logic [DATA_WIDTH:0] sb_q [$];
    int  exp_vals [NUM_PE];
    int  n_checks = 0;
    int  n_fail = 0;
    int  total_shifts = 0;
    int  done_total = 0;
    int  pop_n = 0;
    time last_pop_t = 0;
    time done_t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp();
        for (int i = 0; i < NUM_PE; i++) begin
            logic [DATA_WIDTH-1:0] d;
            d = exp_vals[i][DATA_WIDTH-1:0];
            sb_q.push_back({(i == NUM_PE - 1), d});
        end
    endtask

    task automatic pulse_start(input logic [SHIFT_WIDTH-1:0] rs, input logic sg, input logic ld);
        @(posedge clk); #1;
        start = 1'b1; rshift = rs; out_signed = sg; chain_load = ld;
        @(posedge clk); #1;
        start = 1'b0; chain_load = 1'b0;
        // Scramble the config inputs so only the latched copy can be right.
        rshift = 5'd31; out_signed = ~sg;
    endtask

    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                done_t = $time;
                break;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic monitor();
        logic [DATA_WIDTH:0] got;
        logic [DATA_WIDTH:0] exp;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (pe_shift) total_shifts++;
                if (done) done_total++;
                if (stream_if.out_valid && stream_if.out_ready) begin
                    got = {stream_if.out_last, stream_if.out_data};
                    pop_n++;
                    if (got[DATA_WIDTH]) last_pop_t = $time;
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pop: got %0h required none", got);
                    end else begin
                        exp = sb_q.pop_front();
                        $display("xfer %0d: data=%02h last=%0b expected data=%02h last=%0b",
                                 pop_n, got[DATA_WIDTH-1:0], got[DATA_WIDTH],
                                 exp[DATA_WIDTH-1:0], exp[DATA_WIDTH]);
                        chk("pop_word", 32'(got), 32'(exp));
                    end
                end
            end
        end
    endtask

    initial begin
        int base_shift;
        int base_done;
        int reached;

        stream_if.out_ready = 1'b1;
        chain_mem = '{default: 32'sd0};
        fork
            monitor();
        join_none

        // ---------------- Reset state ----------------
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pe_shift", 32'(pe_shift), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_out_valid", 32'(stream_if.out_valid), 32'd0);
        chk("rst_out_data", 32'(stream_if.out_data), 32'd0);
        chk("rst_out_last", 32'(stream_if.out_last), 32'd0);

        // ---------------- 1: signed basic ----------------
        chain_mem = '{32'sd10, -32'sd10, 32'sd127, 32'sd128, -32'sd129, 32'sd0, 32'sd300, -32'sd300};
        exp_vals  = '{10, -10, 127, 127, -128, 0, 127, -128};
        push_exp();
        base_shift = total_shifts;
        base_done  = done_total;
        pulse_start(5'd0, 1'b1, 1'b1);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_done("t1");
        chk("t1_done_after_last_pop", 32'(done_t - last_pop_t), 32'd10);
        chk("t1_busy_at_done", 32'(busy), 32'd0);
        chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 6: back-to-back, new rshift ----------------
        chain_mem = '{32'sh100, 32'sh200, -32'sh100, 32'sh10000, -32'sh10000, 32'sh7F0, 32'sh800, 32'sd0};
        exp_vals  = '{16, 32, -16, 127, -128, 127, 127, 0};
        push_exp();
        pulse_start(5'd4, 1'b1, 1'b1);
        wait_done("t6");
        repeat (3) @(negedge clk);
        chk("t1t6_shifts", 32'(total_shifts - base_shift), 32'd16);
        chk("t1t6_done_pulses", 32'(done_total - base_done), 32'd2);
        chk("t6_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 2: rounding ----------------
        chain_mem = '{32'sd384, -32'sd384, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
`ifdef DRAIN_ROUND_EN
        exp_vals  = '{2, -1, 0, 0, 0, 0, 0, 0};
`else
        exp_vals  = '{1, -2, 0, 0, 0, 0, 0, 0};
`endif
        push_exp();
        pulse_start(5'd8, 1'b1, 1'b1);
        wait_done("t2");
        chk("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 3: unsigned clamp ----------------
        chain_mem = '{-32'sd5, 32'sd255, 32'sd256, 32'sd0, 32'sd0, 32'sd0, 32'sd0, 32'sd0};
        exp_vals  = '{0, 255, 255, 0, 0, 0, 0, 0};
        push_exp();
        pulse_start(5'd0, 1'b0, 1'b1);
        wait_done("t3");
        chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 4: backpressure ----------------
        chain_mem = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5, 32'sd6, 32'sd7, 32'sd8};
        exp_vals  = '{1, 2, 3, 4, 5, 6, 7, 8};
        push_exp();
        base_shift = total_shifts;
        stream_if.out_ready = 1'b0;
        pulse_start(5'd0, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        chk("t4_stalled_shifts", 32'(total_shifts - base_shift), 32'(FIFO_DEPTH));
        chk("t4_pe_shift_held", 32'(pe_shift), 32'd0);
        chk("t4_out_valid", 32'(stream_if.out_valid), 32'd1);
        @(posedge clk); #1;
        stream_if.out_ready = 1'b1;
        wait_done("t4");
        chk("t4_total_shifts", 32'(total_shifts - base_shift), 32'd8);
        chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 5a: start while busy is ignored ----------------
        chain_mem = '{32'sd1, 32'sd2, 32'sd3, -32'sd4, 32'sd200, -32'sd200, 32'sd5, 32'sd6};
        exp_vals  = '{1, 2, 3, -4, 127, -128, 5, 6};
        push_exp();
        base_shift = total_shifts;
        base_done  = done_total;
        pulse_start(5'd0, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        pulse_start(5'd4, 1'b0, 1'b0);
        wait_done("t5a");
        repeat (4) @(negedge clk);
        chk("t5a_shifts", 32'(total_shifts - base_shift), 32'd8);
        chk("t5a_done_pulses", 32'(done_total - base_done), 32'd1);
        chk("t5a_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---------------- 5b: reset mid-drain ----------------
        stream_if.out_ready = 1'b0;
        base_shift = total_shifts;
        pulse_start(5'd0, 1'b1, 1'b1);
        reached = 0;
        for (int i = 0; i < 50; i++) begin
            if (total_shifts - base_shift >= 3) begin
                reached = 1;
                break;
            end
            @(negedge clk);
        end
        chk("t5b_word3_reached", 32'(reached), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd0);
        chk("t5b_out_valid", 32'(stream_if.out_valid), 32'd0);
        chk("t5b_pe_shift", 32'(pe_shift), 32'd0);
        chk("t5b_done", 32'(done), 32'd0);
        stream_if.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5b_stays_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
